// File: rtl/shifter_iterative_pkg.sv
// Shared encodings for the iterative shifter: shift op codes and controller states.
package shifter_iterative_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shifter_iterative_one_bit.sv
// Single-bit shift stage: moves the operand by one position when Cnt is set,
// passes it through otherwise.
module shifter_one_bit
    import shifter_iterative_pkg::*;
(
    input  logic [WIDTH-1:0] In,
    input  logic             Cnt,
    input  logic [1:0]       Op,
    output logic [WIDTH-1:0] Out
);

    always_comb begin
        Out = In;
        if (Cnt) begin
            case (op_t'(Op))
                OP_ROL:  Out = {In[WIDTH-2:0], In[WIDTH-1]};
                OP_SLL:  Out = {In[WIDTH-2:0], 1'b0};
                OP_SRA:  Out = {In[WIDTH-1], In[WIDTH-1:1]};
                OP_SRL:  Out = {1'b0, In[WIDTH-1:1]};
                default: Out = In;
            endcase
        end
    end

endmodule

// File: rtl/shifter_iterative.sv
// Multi-cycle 16-bit shifter: one single-bit step per clock, Cnt steps total.
//   state | meaning
//   IDLE  | waiting for start; Out holds the last result
//   SHIFT | stepping the data register, counter counts down to zero
//   DONE  | one-cycle result strobe; start here chains the next operation
module shifter_iterative
    import shifter_iterative_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    state_t           state, state_d;
    logic [WIDTH-1:0] data_q, data_d, step_data;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    shifter_one_bit u_step (
        .In  (data_q),
        .Cnt (1'b1),
        .Op  (op_q),
        .Out (step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_ROL;
        end else begin
            state  <= state_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    always_comb begin
        state_d = state;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    data_d  = In;
                    cnt_d   = Cnt;
                    op_d    = Op;
                    state_d = (Cnt != '0) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - 1'b1;
                // Last step is the one taken with the counter still at 1.
                if (cnt_q == 4'd1)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign Out  = data_q;

endmodule
